// File: rtl/hermes_local_injector_if.sv
// hermes_local_injector_if: request, payload and router-side flit handshakes of the local injector
interface hermes_local_injector_if #(
    parameter int FLIT_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic [7:0]            req_target;
    logic [FLIT_WIDTH-1:0] req_size;
    logic                  pl_valid;
    logic                  pl_ready;
    logic [FLIT_WIDTH-1:0] pl_data;
    logic                  tx;
    logic [FLIT_WIDTH-1:0] data_out;
    logic                  credit_i;

    modport master (
        output req_valid, req_target, req_size, pl_valid, pl_data, credit_i,
        input  req_ready, pl_ready, tx, data_out
    );

    modport slave (
        input  req_valid, req_target, req_size, pl_valid, pl_data, credit_i,
        output req_ready, pl_ready, tx, data_out
    );
endinterface

// File: rtl/hermes_local_injector.sv
// hermes_local_injector: serialises header, size and payload flits into the Hermes LOCAL port
module hermes_local_injector #(
    parameter int FLIT_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    hermes_local_injector_if.slave bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

    state_t                state, state_n;
    logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [AW:0]           used;
    logic [FLIT_WIDTH-1:0] remaining, remaining_n;
    logic [FLIT_WIDTH-1:0] data_q, data_n;
    logic [CNT_WIDTH-1:0]  count_n;
    logic                  tx_q, tx_n;
    logic                  push, pop, empty, full, xfer;

    assign empty         = used == '0;
    assign full          = used == (AW+1)'(FIFO_DEPTH);
    assign xfer          = tx_q && bus.credit_i;
    assign bus.pl_ready  = !full && reset;
    assign bus.req_ready = state == IDLE && reset;
    assign push          = bus.pl_valid && bus.pl_ready;
    assign bus.tx        = tx_q;
    assign bus.data_out  = data_q;

    // next state, output flit register and FIFO pop; the size flit is read from remaining, which is untouched until payload
    always_comb begin
        state_n     = state;
        tx_n        = tx_q;
        data_n      = data_q;
        remaining_n = remaining;
        count_n     = pkt_count;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    remaining_n = bus.req_size;
                    data_n      = {{(FLIT_WIDTH-8){1'b0}}, bus.req_target};
                    tx_n        = 1'b1;
                    state_n     = HEADER;
                end
            end
            HEADER: begin
                if (xfer) begin
                    data_n  = remaining;
                    state_n = SIZE;
                end
            end
            SIZE: begin
                if (xfer) begin
                    if (remaining == '0) begin
                        tx_n    = 1'b0;
                        count_n = pkt_count + 1'b1;
                        state_n = IDLE;
                    end else begin
                        pop     = !empty;
                        tx_n    = !empty;
                        data_n  = empty ? data_q : mem[rd_ptr];
                        state_n = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    remaining_n = remaining - 1'b1;
                    if (remaining == FLIT_WIDTH'(1)) begin
                        tx_n    = 1'b0;
                        count_n = pkt_count + 1'b1;
                        state_n = IDLE;
                    end else begin
                        pop    = !empty;
                        tx_n   = !empty;
                        data_n = empty ? data_q : mem[rd_ptr];
                    end
                end else if (!tx_q && !empty) begin
                    pop    = 1'b1;
                    tx_n   = 1'b1;
                    data_n = mem[rd_ptr];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state register, output flit register, packet counter and busy flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            tx_q      <= 1'b0;
            data_q    <= '0;
            remaining <= '0;
            pkt_count <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            tx_q      <= tx_n;
            data_q    <= data_n;
            remaining <= remaining_n;
            pkt_count <= count_n;
            busy      <= state_n != IDLE;
        end
    end

    // payload FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            used   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            used <= used + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // payload FIFO storage, not reset since occupancy gates every read
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.pl_data;
    end
endmodule

// File: tb/tb_hermes_local_injector.sv
// tb_hermes_local_injector: directed and random packets checked against a packet-level flit stream model
module tb_hermes_local_injector;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    logic [15:0] pkt_count;

    hermes_local_injector_if #(.FLIT_WIDTH(16)) bus();

    hermes_local_injector #(.FLIT_WIDTH(16), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .pkt_count(pkt_count)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          phase = 0;
    int          acc_cycle = 0;
    int          a = 0;
    int          n_acc = 0;
    int          n = 0;
    logic [15:0] mcnt = '0;
    logic [7:0]  pk_t[$];
    logic [15:0] pk_s[$];
    logic [15:0] pay_q[$];
    int          xc[$];
    logic        acc_req = 1'b0;
    logic        acc_pl = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_rst = 1'b1;
    logic [15:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // packet-level model: each packet is header, size, then the next size words of the payload stream
    task automatic monitor();
        logic [15:0] e;
        cycle++;
        acc_req = 1'b0;
        acc_pl  = 1'b0;
        if (!reset) begin
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_pl_ready", bus.pl_ready, 0);
            pk_t.delete();
            pk_s.delete();
            pay_q.delete();
            phase      = 0;
            mcnt       = '0;
            prev_stall = 1'b0;
            prev_rst   = 1'b1;
        end else begin
            chk("busy", busy, pk_t.size() > 0);
            chk("pkt_count", pkt_count, mcnt);
            chk("req_ready", bus.req_ready, pk_t.size() == 0);
            if (prev_rst) begin
                chk("rst_tx", bus.tx, 0);
                chk("rst_data", bus.data_out, 0);
            end else if (prev_stall) begin
                chk("stall_tx", bus.tx, 1);
                chk("stall_data", bus.data_out, prev_data);
            end else if (!bus.tx) begin
                chk("idle_hold", bus.data_out, prev_data);
            end
            if (bus.tx && bus.credit_i) begin
                chk("xfer_in_pkt", pk_t.size() != 0, 1);
                if (pk_t.size() != 0) begin
                    if (phase >= 2) chk("payload_avail", pay_q.size() != 0, 1);
                    if (phase < 2 || pay_q.size() != 0) begin
                        e = phase == 0 ? {8'h00, pk_t[0]} : phase == 1 ? pk_s[0] : pay_q.pop_front();
                        chk("flit", bus.data_out, e);
                    end
                    phase++;
                    xc.push_back(cycle);
                    if (phase == int'(pk_s[0]) + 2) begin
                        void'(pk_t.pop_front());
                        void'(pk_s.pop_front());
                        phase = 0;
                        mcnt++;
                    end
                end
            end
            prev_stall = bus.tx && !bus.credit_i;
            prev_data  = bus.data_out;
            prev_rst   = 1'b0;
            if (bus.req_valid && bus.req_ready) begin
                pk_t.push_back(bus.req_target);
                pk_s.push_back(bus.req_size);
                acc_req   = 1'b1;
                acc_cycle = cycle;
            end
            if (bus.pl_valid && bus.pl_ready) begin
                pay_q.push_back(bus.pl_data);
                acc_pl = 1'b1;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) cyc();
    endtask

    task automatic send_req(input logic [7:0] t, input logic [15:0] s);
        int k;
        k = 0;
        bus.req_target = t;
        bus.req_size   = s;
        bus.req_valid  = 1'b1;
        do begin
            cyc();
            k++;
        end while (!acc_req && k < 100);
        bus.req_valid = 1'b0;
        chk("req_accept", acc_req, 1);
    endtask

    task automatic push_word(input logic [15:0] w);
        int k;
        k = 0;
        bus.pl_data  = w;
        bus.pl_valid = 1'b1;
        do begin
            cyc();
            k++;
        end while (!acc_pl && k < 100);
        bus.pl_valid = 1'b0;
        chk("pl_accept", acc_pl, 1);
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (pk_t.size() > 0 && k < bound) begin
            cyc();
            k++;
        end
        chk("drain", pk_t.size(), 0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_target = '0;
        bus.req_size   = '0;
        bus.pl_valid   = 1'b0;
        bus.pl_data    = '0;
        bus.credit_i   = 1'b1;
        idle(2);
        reset = 1'b1;
        idle(1);

        push_word(16'h0002);
        xc.delete();
        send_req(8'h12, 16'd1);
        a = acc_cycle;
        drain(20);
        chk("t1_nflits", xc.size(), 3);
        chk("t1_first", xc[0], a + 1);
        chk("t1_last", xc[2], a + 3);
        idle(1);
        chk("t1_tx_off", bus.tx, 0);
        chk("t1_cnt", pkt_count, 1);

        push_word(16'($urandom));
        xc.delete();
        send_req(8'h21, 16'd0);
        drain(20);
        chk("t2_nflits", xc.size(), 2);
        idle(1);
        chk("t2_cnt", pkt_count, 2);

        push_word(16'($urandom));
        push_word(16'($urandom));
        xc.delete();
        send_req(8'($urandom), 16'd3);
        a = acc_cycle;
        cyc();
        bus.credit_i = 1'b0;
        idle(2);
        bus.credit_i = 1'b1;
        idle(2);
        bus.credit_i = 1'b0;
        cyc();
        bus.credit_i = 1'b1;
        drain(20);
        chk("t3_nflits", xc.size(), 5);
        chk("t3_first", xc[0], a + 1);
        chk("t3_span", xc[4] - xc[0] + 1, 8);

        xc.delete();
        send_req(8'($urandom), 16'd6);
        a = acc_cycle;
        for (int i = 0; i < 6; i++) begin
            push_word(16'($urandom));
            idle(2);
        end
        drain(20);
        chk("t4_nflits", xc.size(), 8);
        chk("t4_p0", xc[2], a + 3);
        chk("t4_last", xc[7], a + 18);

        n_acc = 0;
        bus.pl_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.pl_data = 16'($urandom);
            cyc();
            n_acc += int'(acc_pl);
        end
        bus.pl_valid = 1'b0;
        chk("t4_accepted", n_acc, 4);
        chk("t4_full", bus.pl_ready, 0);
        send_req(8'($urandom), 16'd6);
        push_word(16'($urandom));
        push_word(16'($urandom));
        drain(40);

        for (int i = 0; i < 3; i++) push_word(16'($urandom));
        xc.delete();
        send_req(8'($urandom), 16'd2);
        send_req(8'($urandom), 16'd1);
        drain(30);
        chk("t5_nflits", xc.size(), 7);
        chk("t5_gap", xc[4] - xc[3], 2);
        idle(1);
        chk("t5_cnt", pkt_count, 7);

        for (int i = 0; i < 4; i++) push_word(16'($urandom));
        send_req(8'($urandom), 16'd4);
        idle(3);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        chk("t6_busy", busy, 0);
        chk("t6_cnt", pkt_count, 0);
        push_word(16'($urandom));
        push_word(16'($urandom));
        send_req(8'($urandom), 16'd2);
        drain(20);
        idle(1);
        chk("t6_cnt_after", pkt_count, 1);

        for (int i = 0; i < 800; i++) begin
            bus.credit_i   = ($urandom % 4) != 0;
            bus.pl_valid   = ($urandom % 2) != 0;
            bus.pl_data    = 16'($urandom);
            bus.req_valid  = ($urandom % 3) == 0;
            bus.req_target = 8'($urandom);
            bus.req_size   = 16'($urandom % 10);
            cyc();
        end
        bus.req_valid = 1'b0;
        bus.credit_i  = 1'b1;
        n = 0;
        while (pk_t.size() > 0 && n < 500) begin
            bus.pl_valid = 1'b1;
            bus.pl_data  = 16'($urandom);
            cyc();
            n++;
        end
        bus.pl_valid = 1'b0;
        chk("rand_drain", pk_t.size(), 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
